// File: rtl/aes_uart_block_ctrl.sv
// rtl/aes_uart_block_ctrl.sv - UART byte <-> AES-128 block sequencer
// Collects 16 bytes into a block, starts the core, then returns the result byte by byte.
module aes_uart_block_ctrl #(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] plaintext,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_ready,
    output logic         busy,
    output logic         rx_err,
    output logic         overrun
);

    typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND, GAP} state_t;

    localparam logic [4:0]       LAST_SLOT = 5'(BLOCK_BYTES - 1);
    localparam logic [4:0]       ALL_SENT  = 5'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [4:0]         byte_cnt;
    logic [CNT_W-1:0]   timer;
    logic [127:0]       result;
    logic [6:0]         slot_base;

    // Big-endian slot: byte 0 occupies bits [127:120], byte 15 bits [7:0].
    assign slot_base = {~byte_cnt[3:0], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            timer     <= '0;
            plaintext <= '0;
            result    <= '0;
            tx_data   <= '0;
            aes_start <= 1'b0;
            tx_start  <= 1'b0;
            rx_err    <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            aes_start <= 1'b0;
            tx_start  <= 1'b0;
            rx_err    <= 1'b0;

            if (rx_valid && (state == START || state == WAIT ||
                             state == SEND  || state == GAP))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        plaintext[slot_base +: 8] <= rx_data;
                        byte_cnt <= 5'd1;
                        timer    <= '0;
                        busy     <= 1'b1;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    // A byte on the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        plaintext[slot_base +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 5'd1;
                        timer    <= '0;
                        if (byte_cnt == LAST_SLOT) begin
                            aes_start <= 1'b1;
                            state     <= START;
                        end
                    end else if (timer == TMO_LAST) begin
                        rx_err   <= 1'b1;
                        byte_cnt <= '0;
                        timer    <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (aes_done) begin
                        result   <= aes_result;
                        byte_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_data  <= result[slot_base +: 8];
                        tx_start <= 1'b1;
                        byte_cnt <= byte_cnt + 5'd1;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    // One dead cycle so the transmitter can drop tx_ready.
                    if (byte_cnt == ALL_SENT) begin
                        byte_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_uart_block_ctrl.sv
// tb/tb_aes_uart_block_ctrl.sv - directed self-checking bench for aes_uart_block_ctrl
module tb_aes_uart_block_ctrl;

    localparam logic [127:0] PT1  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] RES1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RES2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK3 = 128'h1032547698badcfe0f1e2d3c4b5a6978;
    localparam logic [127:0] RES3 = 128'hdeadbeef0badf00dcafef00d12345678;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [127:0] plaintext;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_ready = 1'b1;
    logic         busy;
    logic         rx_err;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_rxerr  = 0;
    int n_tx     = 0;
    int hold     = 0;
    bit bp_mode  = 1'b0;
    logic       rdy_at_edge;
    logic [7:0] tx_log [0:63];
    int         tx_cyc [0:63];

    aes_uart_block_ctrl #(.TIMEOUT_CYCLES(100), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .plaintext(plaintext), .aes_start(aes_start), .aes_done(aes_done),
        .aes_result(aes_result), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .busy(busy), .rx_err(rx_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[(127 - 8*i) -: 8];
    endfunction

    // Output monitor and transmitter model, sampling just after each rising edge.
    always @(posedge clk) begin
        rdy_at_edge = tx_ready;
        #1;
        cyc++;
        if (aes_start) n_start++;
        if (rx_err) n_rxerr++;
        if (tx_start) begin
            check("tx_ready_at_start", 128'(rdy_at_edge), 128'd1);
            if (n_tx < 64) begin
                tx_log[n_tx] = tx_data;
                tx_cyc[n_tx] = cyc;
            end
            n_tx++;
            if (bp_mode) begin
                tx_ready = 1'b0;
                hold = 50;
            end
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) tx_ready = 1'b1;
        end
    end

    task automatic send_block(input logic [127:0] blk, input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            rx_data  = byte_of(blk, i);
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic [127:0] r);
        aes_result = r;
        aes_done   = 1'b1;
        @(negedge clk);
        aes_done   = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (n_tx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_count", 128'(n_tx), 128'(target));
    endtask

    task automatic check_bytes(input string tag, input logic [127:0] r, input int base, input int count);
        for (int i = 0; i < count; i++)
            check(tag, 128'(tx_log[base + i]), 128'(byte_of(r, i)));
    endtask

    initial begin
        int n;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_plaintext", plaintext, 128'd0);
        check("rst_tx_data", 128'(tx_data), 128'd0);
        check("rst_pulses", 128'({aes_start, tx_start, rx_err, overrun}), 128'd0);
        rst = 1'b0;

        // aes_done while idle must be ignored
        pulse_done(RES2);
        repeat (5) @(negedge clk);
        check("idle_done_busy", 128'(busy), 128'd0);
        check("idle_done_tx", 128'(n_tx), 128'd0);

        // Block 1: nominal assembly and serialisation
        send_block(PT1, 0, 15, 20);
        check("b1_start_latency", 128'(aes_start), 128'd1);
        check("b1_plaintext", plaintext, PT1);
        @(negedge clk);
        check("b1_start_width", 128'(aes_start), 128'd0);
        check("b1_busy", 128'(busy), 128'd1);
        repeat (3) @(negedge clk);
        pulse_done(RES1);
        wait_tx(16, 100);
        check_bytes("b1_tx_byte", RES1, 0, 16);
        for (int i = 1; i < 16; i++)
            check("b1_tx_spacing", 128'(tx_cyc[i] - tx_cyc[i-1]), 128'd2);
        @(negedge clk);
        check("b1_busy_end", 128'(busy), 128'd0);
        check("b1_start_count", 128'(n_start), 128'd1);

        // Block 2: done in START ignored, overrun in WAIT, transmitter backpressure
        send_block(~PT1, 0, 15, 5);
        check("b2_plaintext", plaintext, ~PT1);
        pulse_done(RES1);
        repeat (5) @(negedge clk);
        check("b2_early_done_tx", 128'(n_tx), 128'd16);
        check("b2_wait_busy", 128'(busy), 128'd1);
        rx_data  = 8'haa;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("b2_overrun_set", 128'(overrun), 128'd1);
        check("b2_plaintext_kept", plaintext, ~PT1);
        bp_mode = 1'b1;
        pulse_done(RES2);
        wait_tx(32, 16 * 60);
        check_bytes("b2_tx_byte", RES2, 16, 16);
        repeat (60) @(negedge clk);
        bp_mode = 1'b0;
        check("b2_busy_end", 128'(busy), 128'd0);
        check("b2_overrun_sticky", 128'(overrun), 128'd1);

        // Timeout on a 5-byte partial block
        send_block(BLK3, 0, 4, 0);
        n = 0;
        while (!rx_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_delay", 128'(n), 128'd100);
        @(negedge clk);
        check("tmo_pulse_width", 128'(rx_err), 128'd0);
        check("tmo_busy", 128'(busy), 128'd0);
        check("tmo_plaintext", plaintext, {BLK3[127:88], ~PT1[87:0]});
        check("tmo_rxerr_count", 128'(n_rxerr), 128'd1);

        // Byte exactly on the expiry cycle keeps the block alive
        send_block(BLK3, 0, 2, 0);
        repeat (99) @(negedge clk);
        send_block(BLK3, 3, 15, 0);
        check("exp_start", 128'(aes_start), 128'd1);
        check("exp_plaintext", plaintext, BLK3);
        check("exp_rxerr_count", 128'(n_rxerr), 128'd1);

        // Reset in the middle of sending
        repeat (2) @(negedge clk);
        pulse_done(RES3);
        wait_tx(39, 100);
        check_bytes("b3_tx_byte", RES3, 32, 7);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_tx_data", 128'(tx_data), 128'd0);
        check("mid_rst_plaintext", plaintext, 128'd0);
        check("mid_rst_pulses", 128'({aes_start, tx_start, rx_err, overrun}), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_tx", 128'(n_tx), 128'd39);
        check("post_rst_start", 128'(n_start), 128'd3);

        // Clean block after reset
        send_block(PT1, 0, 15, 3);
        check("b4_plaintext", plaintext, PT1);
        repeat (2) @(negedge clk);
        pulse_done(RES1);
        wait_tx(55, 100);
        check_bytes("b4_tx_byte", RES1, 39, 16);
        check("b4_overrun", 128'(overrun), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_uart_block_ctrl.md
Name: aes_uart_block_ctrl

Overview:
- Sequencer between the UART byte interface and the AES-128 datapath.
- Assembles 16 received bytes into a 128-bit plaintext block, which is fed to the state-array mapper and AES core.
- Issues a start pulse, waits for completion, then serialises the 128-bit result back out as 16 transmit bytes.
- Handles inter-byte timeout, overrun and transmitter backpressure.

Parameters:
- BLOCK_BYTES, 16, bytes per block; fixed at 16 for AES-128, must not be overridden.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between received bytes of a partial block before it is discarded.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
- plaintext  output  128  assembled block to state mapper/AES core.
- aes_start  output  1  one-cycle start pulse to AES core.
- aes_done  input  1  one-cycle completion pulse from AES core.
- aes_result  input  128  ciphertext; valid in the cycle aes_done is high.
- tx_data  output  8  byte to UART transmitter.
- tx_start  output  1  one-cycle transmit request.
- tx_ready  input  1  transmitter idle and able to accept a byte.
- busy  output  1  high in every state except IDLE.
- rx_err  output  1  one-cycle pulse when a partial block is discarded on timeout.
- overrun  output  1  sticky flag: a byte arrived while not accepting; cleared only by rst.

Behaviour:
- Reset (async, any state): state=IDLE, byte_cnt=0, timer=0, plaintext=0, result reg=0, tx_data=0, aes_start=0, tx_start=0, rx_err=0, overrun=0, busy=0.
- Byte order is big-endian:
  - First received byte → plaintext[127:120]; 16th byte → plaintext[7:0].
  - Transmit order is aes_result[127:120] first.
- States:
  - IDLE: rx_valid → write byte into slot 0, byte_cnt=1, go RECV.
  - RECV:
    - rx_valid → write slot byte_cnt, byte_cnt+1, timer=0.
    - When the 16th byte is written → go START.
    - With no rx_valid, timer increments. Timer reaching TIMEOUT_CYCLES-1 → pulse rx_err, byte_cnt=0, go IDLE. plaintext is left as-is but is not started.
  - START: aes_start=1 for exactly this cycle; go WAIT. Latency: aes_start is high the cycle after the 16th rx_valid.
  - WAIT: aes_done → capture aes_result into internal result register, byte_cnt=0, go SEND.
  - SEND:
    - tx_ready=1 → tx_data = result byte byte_cnt, tx_start=1 for one cycle, byte_cnt+1, go GAP.
    - tx_ready=0 → hold; no timeout.
  - GAP: ignore tx_ready for exactly one cycle (lets the transmitter deassert ready), then go SEND. After the 16th byte, go IDLE instead.
- plaintext holds its value from the 16th byte until the first byte of the next block overwrites slot 0. The AES core samples it no later than aes_start.
- tx_data holds the last transmitted byte until the next tx_start.
- Boundary conditions:
  - rx_valid in START, WAIT, SEND or GAP → byte dropped, overrun set.
  - rx_valid in the same cycle RECV times out → the byte is accepted and the timer reset; no rx_err.
  - aes_done outside WAIT is ignored.
  - aes_done arriving in the START cycle is ignored; the core must not complete in 0 cycles.
  - rx_valid in IDLE in the same cycle as the final GAP→IDLE transition is not possible: GAP is not IDLE, so the byte counts as overrun.
  - byte_cnt is 5 bits wide; it never exceeds 16 and never wraps.
  - rst asserted mid-RECV or mid-SEND: partial data is abandoned and outputs go to their reset values immediately. No stray tx_start or aes_start follows reset release.

Test Plan:
- Nominal assembly: send bytes 01,23,45,67,89,ab,cd,ef,fe,dc,ba,98,76,54,32,10 with random 0-20 cycle gaps → plaintext = 128'h0123456789abcdeffedcba9876543210; aes_start high exactly 1 cycle, the cycle after the 16th strobe.
- Result serialisation: aes_done with aes_result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a, tx_ready held 1 → 16 tx_start pulses, each 2 cycles apart, carrying 69,c4,e0,…,c5,5a; busy falls after the last one.
- Backpressure: the transmitter model drops tx_ready for 50 cycles after each tx_start → no tx_start while tx_ready=0; byte sequence unchanged; no byte lost or duplicated.
- Timeout (TIMEOUT_CYCLES=100): send 5 bytes, then silence → rx_err pulses exactly once, 100 cycles after the 5th byte; then 16 new bytes assemble correctly from slot 0. A byte arriving on the expiry cycle produces no rx_err.
- Overrun: inject rx_valid=1, rx_data=aa during WAIT → overrun=1 and stays 1; the next block and result are unaffected.
- Reset mid-operation: assert rst after tx byte 7 → all outputs at reset values in the same cycle. After release, no tx_start until a full new block is received and processed.
